// File: rtl/imem_responder.sv
// Instruction memory responder: line-wide fetch with fixed latency
// and a backdoor port for loading the program one word at a time.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef BUS_LEN
`define BUS_LEN 2
`endif
`ifndef BUS_WID
`define BUS_WID (32*`BUS_LEN)
`endif

module imem_responder #(
    parameter int LATENCY    = 1,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                imem_req,
    input  logic [`XLEN-1:0]    imem_addr,
    output logic [`BUS_WID-1:0] imem_rdata,
    output logic                imem_resp,
    input  logic                load_vld,
    input  logic [`XLEN-1:0]    load_addr,
    input  logic [31:0]         load_data,
    output logic                busy,
    output logic                proto_err
);

    localparam int OFS   = $clog2(4 * `BUS_LEN);
    localparam int LINES = 2 ** DEPTH_LOG2;

    typedef enum logic [0:0] {
        IDLE,
        WAIT
    } state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic [`BUS_WID-1:0] mem [LINES];
    logic [`BUS_WID-1:0] hold_q;
    logic [`BUS_WID-1:0] rdata_q;

    logic [DEPTH_LOG2-1:0] req_line;
    logic [DEPTH_LOG2-1:0] ld_line;
    logic [OFS+2:0]        ld_bit;
    logic                  accept;

    assign req_line = imem_addr[OFS+DEPTH_LOG2-1:OFS];
    assign ld_line  = load_addr[OFS+DEPTH_LOG2-1:OFS];
    assign ld_bit   = {load_addr[OFS-1:2], 5'd0};

    // Address bits outside the line index are deliberately don't-care.
    logic unused_bits;
    assign unused_bits = ^{imem_addr[`XLEN-1:OFS+DEPTH_LOG2],
                           imem_addr[OFS-1:0],
                           load_addr[`XLEN-1:OFS+DEPTH_LOG2],
                           load_addr[1:0]};

    assign imem_resp  = !rst && (state_q == WAIT) && (cnt_q == 4'd0);
    assign busy       = !rst && (state_q == WAIT);
    assign accept     = imem_req && !rst &&
                        ((state_q == IDLE) || imem_resp);
    assign imem_rdata = imem_resp ? hold_q : rdata_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = WAIT;
                    cnt_d   = 4'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (accept) begin
                    cnt_d = 4'(LATENCY - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            hold_q    <= '0;
            rdata_q   <= '0;
            proto_err <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // Nonblocking read: a same-cycle load is not seen here.
            if (accept) begin
                hold_q <= mem[req_line];
            end
            if (imem_resp) begin
                rdata_q <= hold_q;
            end
            if (imem_req && (state_q == WAIT) && !imem_resp) begin
                proto_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && load_vld) begin
            mem[ld_line][ld_bit +: 32] <= load_data;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: cycle table at LATENCY=2,
// then a back-to-back sequence on a LATENCY=1 instance.
module tb_imem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req = 1'b0;
    logic [31:0] imem_addr = '0;
    logic        load_vld = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;

    logic [63:0] rdata2, rdata1;
    logic        resp2, resp1, busy2, busy1, perr2, perr1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    imem_responder #(.LATENCY(2), .DEPTH_LOG2(12)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(rdata2), .imem_resp(resp2),
        .load_vld(load_vld), .load_addr(load_addr),
        .load_data(load_data),
        .busy(busy2), .proto_err(perr2)
    );

    imem_responder #(.LATENCY(1), .DEPTH_LOG2(12)) dut1 (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(rdata1), .imem_resp(resp1),
        .load_vld(load_vld), .load_addr(load_addr),
        .load_data(load_data),
        .busy(busy1), .proto_err(perr1)
    );

    typedef struct {
        bit        r;
        bit        q;
        bit [31:0] a;
        bit        lv;
        bit [31:0] la;
        bit [31:0] ld;
        bit        e_resp;
        bit        e_busy;
        bit        e_perr;
        bit        chk;
        bit [63:0] e_rdata;
    } vec_t;

    localparam int NV = 32;
    vec_t vecs [NV];

    function automatic vec_t v(bit r, bit q, bit [31:0] a,
                               bit lv, bit [31:0] la, bit [31:0] ld,
                               bit er, bit eb, bit ep,
                               bit ck, bit [63:0] ed);
        vec_t x;
        x.r = r; x.q = q; x.a = a;
        x.lv = lv; x.la = la; x.ld = ld;
        x.e_resp = er; x.e_busy = eb; x.e_perr = ep;
        x.chk = ck; x.e_rdata = ed;
        return x;
    endfunction

    task automatic check(string name, logic [63:0] act,
                         logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    localparam logic [63:0] L200  = 64'h00100093_00000013;
    localparam logic [63:0] L208  = 64'hBBBB0002_AAAA0001;
    localparam logic [63:0] L200B = 64'h00100093_DEADBEEF;
    localparam logic [63:0] L210  = 64'h44444444_11111111;

    initial begin
        logic [31:0] addrs [4];
        logic [63:0] lines [4];

        vecs[0]  = v(1,0,0,     0,0,0,            0,0,0, 1,64'h0);
        vecs[1]  = v(0,0,0,     1,32'h210,32'h11111111, 0,0,0, 0,0);
        vecs[2]  = v(0,0,0,     1,32'h214,32'h44444444, 0,0,0, 0,0);
        vecs[3]  = v(1,0,0,     1,32'h210,32'h22222222, 0,0,0, 0,0);
        vecs[4]  = v(0,0,0,     1,32'h200,32'h00000013, 0,0,0, 0,0);
        vecs[5]  = v(0,0,0,     1,32'h204,32'h00100093, 0,0,0, 0,0);
        vecs[6]  = v(0,0,0,     1,32'h208,32'hAAAA0001, 0,0,0, 0,0);
        vecs[7]  = v(0,0,0,     1,32'h20C,32'hBBBB0002, 0,0,0, 0,0);
        vecs[8]  = v(0,1,32'h200, 0,0,0,          0,0,0, 0,0);
        vecs[9]  = v(0,0,0,     0,0,0,            0,1,0, 0,0);
        vecs[10] = v(0,1,32'h208, 0,0,0,          1,1,0, 1,L200);
        vecs[11] = v(0,0,0,     0,0,0,            0,1,0, 1,L200);
        vecs[12] = v(0,0,0,     0,0,0,            1,1,0, 1,L208);
        vecs[13] = v(0,1,32'h200, 1,32'h200,32'hDEADBEEF,
                                                  0,0,0, 1,L208);
        vecs[14] = v(0,0,0,     0,0,0,            0,1,0, 0,0);
        vecs[15] = v(0,0,0,     0,0,0,            1,1,0, 1,L200);
        vecs[16] = v(0,1,32'h8200, 0,0,0,         0,0,0, 0,0);
        vecs[17] = v(0,0,0,     0,0,0,            0,1,0, 0,0);
        vecs[18] = v(0,1,32'h210, 0,0,0,          1,1,0, 1,L200B);
        vecs[19] = v(0,0,0,     0,0,0,            0,1,0, 0,0);
        vecs[20] = v(0,0,0,     0,0,0,            1,1,0, 1,L210);
        vecs[21] = v(0,1,32'h200, 0,0,0,          0,0,0, 0,0);
        vecs[22] = v(0,1,32'h208, 0,0,0,          0,1,0, 0,0);
        vecs[23] = v(0,0,0,     0,0,0,            1,1,1, 1,L200B);
        vecs[24] = v(0,0,0,     0,0,0,            0,0,1, 1,L200B);
        vecs[25] = v(1,1,32'h200, 0,0,0,          0,0,1, 0,0);
        vecs[26] = v(0,0,0,     0,0,0,            0,0,0, 1,64'h0);
        vecs[27] = v(0,1,32'h200, 0,0,0,          0,0,0, 0,0);
        vecs[28] = v(1,0,0,     0,0,0,            0,0,0, 0,0);
        vecs[29] = v(0,0,0,     0,0,0,            0,0,0, 1,64'h0);
        vecs[30] = v(0,0,0,     0,0,0,            0,0,0, 1,64'h0);
        vecs[31] = v(0,0,0,     0,0,0,            0,0,0, 0,0);

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            rst       = vecs[i].r;
            imem_req  = vecs[i].q;
            imem_addr = vecs[i].a;
            load_vld  = vecs[i].lv;
            load_addr = vecs[i].la;
            load_data = vecs[i].ld;
            #4;
            check($sformatf("c%0d resp", i), 64'(resp2),
                  64'(vecs[i].e_resp));
            check($sformatf("c%0d busy", i), 64'(busy2),
                  64'(vecs[i].e_busy));
            check($sformatf("c%0d proto_err", i), 64'(perr2),
                  64'(vecs[i].e_perr));
            if (vecs[i].chk)
                check($sformatf("c%0d rdata", i), rdata2,
                      vecs[i].e_rdata);
        end

        addrs[0] = 32'h200;  lines[0] = L200B;
        addrs[1] = 32'h208;  lines[1] = L208;
        addrs[2] = 32'h210;  lines[2] = L210;
        addrs[3] = 32'h8200; lines[3] = L200B;

        @(posedge clk);
        #1;
        rst = 1'b1; imem_req = 1'b0; load_vld = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #4;
        check("lat1 reset busy", 64'(busy1), 64'h0);

        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            imem_req  = (k < 4);
            imem_addr = (k < 4) ? addrs[k] : 32'h0;
            #4;
            check($sformatf("lat1 k%0d resp", k), 64'(resp1),
                  64'(k >= 1 && k <= 4));
            check($sformatf("lat1 k%0d busy", k), 64'(busy1),
                  64'(k >= 1 && k <= 4));
            check($sformatf("lat1 k%0d proto_err", k), 64'(perr1),
                  64'h0);
            if (k >= 1 && k <= 4)
                check($sformatf("lat1 k%0d rdata", k), rdata1,
                      lines[k-1]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter LATENCY, default 1, SHALL be the cycles from request acceptance to imem_resp, legal range 1..15.
REQ-002 Parameter DEPTH_LOG2, default 12, SHALL set the line count of the internal array to 2^DEPTH_LOG2 lines of `BUS_WID bits.
REQ-003 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port imem_req, input, 1: fetch request, one-cycle qualifier for imem_addr.
REQ-006 Port imem_addr, input, `XLEN: line-aligned byte fetch address.
REQ-007 Port imem_rdata, output, `BUS_WID: fetched line; instruction k occupies bits [32k+31:32k].
REQ-008 Port imem_resp, output, 1: one-cycle response strobe qualifying imem_rdata.
REQ-009 Port load_vld, input, 1: backdoor program-load write strobe.
REQ-010 Port load_addr, input, `XLEN: byte address of the 32-bit instruction being loaded.
REQ-011 Port load_data, input, 32: instruction word to load.
REQ-012 Port busy, output, 1: a request is accepted and its response not yet delivered.
REQ-013 Port proto_err, output, 1: sticky protocol-violation flag.

Function
REQ-014 Line index SHALL be imem_addr[OFS+DEPTH_LOG2-1:OFS], OFS=log2(4*`BUS_LEN); higher bits ignored (address wraps modulo array size); bits below OFS ignored.
REQ-015 Load SHALL write load_data into lane load_addr[OFS-1:2] of line load_addr[OFS+DEPTH_LOG2-1:OFS] on the cycle load_vld=1; other lanes unchanged.
REQ-016 FSM states SHALL be IDLE and WAIT; a request is accepted when imem_req=1 and (state=IDLE or imem_resp=1 in that cycle).
REQ-017 On acceptance the array line SHALL be read that cycle into a holding register; a same-cycle load to that line SHALL NOT affect the captured data.
REQ-018 On acceptance the FSM SHALL enter WAIT with down-counter = LATENCY-1; imem_resp SHALL assert in the cycle the counter is 0 in WAIT, i.e. exactly LATENCY cycles after acceptance.
REQ-019 imem_resp SHALL be high for exactly one cycle per accepted request, with imem_rdata equal to the captured line in that cycle.
REQ-020 After imem_resp the FSM SHALL return to IDLE unless a request was accepted in the same cycle, in which case it SHALL stay in WAIT with a reloaded counter (back-to-back, no bubble).
REQ-021 imem_rdata SHALL hold its last value between responses.
REQ-022 imem_req=1 in WAIT while imem_resp=0 SHALL be ignored (no response, pending request unaffected) and SHALL set proto_err, which stays 1 until reset.
REQ-023 busy SHALL be 1 exactly when state=WAIT.
REQ-024 Throughput with one outstanding request SHALL be one line per LATENCY cycles.

Reset
REQ-025 During rst: state=IDLE, counter=0, imem_resp=0, imem_rdata=0, busy=0, proto_err=0.
REQ-026 Reset during WAIT SHALL drop the pending request; no imem_resp for it after reset release.
REQ-027 Array contents SHALL NOT be reset; loads during rst SHALL be ignored.
REQ-028 imem_req asserted during rst SHALL NOT be accepted.

Verification (BUS_LEN=2, BUS_WID=64, OFS=3, LATENCY=2 unless stated)
REQ-029 Load 'h13 at 'h200, 'h00100093 at 'h204; req 'h200 at cycle t -> resp=1 only at t+2, rdata='h00100093_00000013, busy=1 at t+1..t+2.
REQ-030 Req 'h200 at t, req 'h208 at t+2 (resp cycle) -> resp at t+2 and t+4, busy continuously high t+1..t+4, proto_err=0.
REQ-031 Req at t, second req at t+1 -> one resp at t+2, second req dropped, proto_err=1 and held.
REQ-032 LATENCY=1: req every cycle from t for 4 cycles -> resp at t+1..t+4, each with the line of the prior cycle's address.
REQ-033 Req 'h200 at t with same-cycle load of 'hDEADBEEF to 'h200 -> resp at t+2 returns old low word; next req to 'h200 returns 'hDEADBEEF.
REQ-034 Req at t, rst at t+1 -> no resp at t+2 or later, busy=0, proto_err=0; address 'h200+2^15 (DEPTH_LOG2=12) returns line 'h200.
